// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with 16x oversampling that turns ASCII command bytes
// into stopwatch strobes.
// Ports: clk, rst (sync, active high), rx (async serial in, idle high);
//        o_rx_data (last good byte), o_rx_done / o_frame_err (1-clk strobes),
//        o_runstop / o_clear (1-clk command strobes), o_option (toggled level).
module uart_cmd_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_runstop,
  output logic       o_clear,
  output logic       o_option
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_m_q, rx_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          rs_q, rs_d;
  logic          clr_q, clr_d;
  logic          opt_q, opt_d;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      div_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rs_q    <= 1'b0;
      clr_q   <= 1'b0;
      opt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      rs_q    <= rs_d;
      clr_q   <= clr_d;
      opt_q   <= opt_d;
    end
  end

  assign tick = (div_q == DW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    // Decode the byte published last cycle; only one match is possible.
    rs_d    = done_q && (data_q == 8'h52 || data_q == 8'h72);
    clr_d   = done_q && (data_q == 8'h43 || data_q == 8'h63);
    opt_d   = opt_q ^ (done_q && (data_q == 8'h4D || data_q == 8'h6D));

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          tcnt_d  = '0;
          // Align tick phase to the falling edge.
          div_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == 4'd15) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            if (bcnt_q == 3'd7) state_d = STOP;
            else bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          // Leave mid stop bit so a following start edge is not missed.
          if (tcnt_q == 4'd15) begin
            state_d = IDLE;
            if (rx_s_q) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rx_data   = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_runstop   = rs_q;
  assign o_clear     = clr_q;
  assign o_option    = opt_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at a scaled-down baud (1 bit = 64 clk).
// Table-driven frames plus glitch, reset-abort and back-to-back sequences.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 640_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done, o_frame_err, o_runstop, o_clear, o_option;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .o_rx_data(o_rx_data), .o_rx_done(o_rx_done),
    .o_frame_err(o_frame_err), .o_runstop(o_runstop),
    .o_clear(o_clear), .o_option(o_option)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_done = 0, n_ferr = 0, n_rs = 0, n_clr = 0, n_bad = 0;
  logic prev_done = 1'b0;

  // Pulse counters; command strobes must follow a done strobe directly.
  always @(negedge clk) begin
    if (o_rx_done) n_done <= n_done + 1;
    if (o_frame_err) n_ferr <= n_ferr + 1;
    if (o_runstop) n_rs <= n_rs + 1;
    if (o_clear) n_clr <= n_clr + 1;
    if (((o_runstop || o_clear) && !prev_done) || (o_runstop && o_clear))
      n_bad <= n_bad + 1;
    prev_done <= o_rx_done;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input int gap);
    @(negedge clk) rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (stop_ok ? BIT : (BIT * 3) / 4) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         e_done;
    int         e_ferr;
    int         e_rs;
    int         e_clr;
    logic       e_opt;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs [6];
  int b_done, b_ferr, b_rs, b_clr;

  task automatic snap();
    b_done = n_done; b_ferr = n_ferr; b_rs = n_rs; b_clr = n_clr;
  endtask

  initial begin
    vecs[0] = '{8'h52, 1'b1, 1, 0, 1, 0, 1'b0, 8'h52};
    vecs[1] = '{8'h6D, 1'b1, 1, 0, 0, 0, 1'b1, 8'h6D};
    vecs[2] = '{8'h4D, 1'b1, 1, 0, 0, 0, 1'b0, 8'h4D};
    vecs[3] = '{8'h43, 1'b0, 0, 1, 0, 0, 1'b0, 8'h4D};
    vecs[4] = '{8'h63, 1'b1, 1, 0, 0, 1, 1'b0, 8'h63};
    vecs[5] = '{8'h7A, 1'b1, 1, 0, 0, 0, 1'b0, 8'h7A};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({o_rx_data, o_rx_done, o_frame_err, o_runstop, o_clear, o_option}),
        0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      snap();
      send_frame(vecs[v].data, vecs[v].stop_ok, 2 * BIT);
      chk($sformatf("v%0d_done", v), n_done - b_done, vecs[v].e_done);
      chk($sformatf("v%0d_ferr", v), n_ferr - b_ferr, vecs[v].e_ferr);
      chk($sformatf("v%0d_runstop", v), n_rs - b_rs, vecs[v].e_rs);
      chk($sformatf("v%0d_clear", v), n_clr - b_clr, vecs[v].e_clr);
      chk($sformatf("v%0d_option", v), int'(o_option), int'(vecs[v].e_opt));
      chk($sformatf("v%0d_data", v), int'(o_rx_data), int'(vecs[v].e_data));
    end

    // Short low pulse: rejected at mid start bit.
    snap();
    @(negedge clk) rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    chk("glitch_done", n_done - b_done, 0);
    chk("glitch_ferr", n_ferr - b_ferr, 0);
    chk("glitch_data", int'(o_rx_data), 8'h7A);

    // Set option, then abort a frame with reset during data bit 4.
    send_frame(8'h6D, 1'b1, 2 * BIT);
    chk("opt_before_rst", int'(o_option), 1);
    snap();
    @(negedge clk) rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 1) ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs",
        int'({o_rx_data, o_rx_done, o_frame_err, o_runstop, o_clear, o_option}),
        0);
    repeat (12 * BIT) @(negedge clk);
    chk("rst_no_strobes", (n_done - b_done) + (n_ferr - b_ferr), 0);
    snap();
    send_frame(8'h63, 1'b1, 2 * BIT);
    chk("post_rst_clear", n_clr - b_clr, 1);
    chk("post_rst_data", int'(o_rx_data), 8'h63);

    // Back-to-back frames with no idle gap.
    snap();
    send_frame(8'h41, 1'b1, 0);
    chk("b2b_first_data", int'(o_rx_data), 8'h41);
    send_frame(8'h72, 1'b1, 2 * BIT);
    chk("b2b_done", n_done - b_done, 2);
    chk("b2b_runstop", n_rs - b_rs, 1);
    chk("b2b_clear", n_clr - b_clr, 0);
    chk("b2b_data", int'(o_rx_data), 8'h72);

    chk("strobe_alignment", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
